config_receiver: RTL and testbench
==================================

CONFIG_RECEIVER -- requirements
Module: config_receiver

Interface
REQ-001 SHALL have parameter CFG_BITS, default 52, meaning number of serial bits per configuration frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of each input synchronizer (min 2).
REQ-003 SHALL have port clk  input  1  system/pixel clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cfg_en  input  1  frame enable from external loader; high for the whole frame.
REQ-006 SHALL have port cfg_sclk  input  1  serial bit clock; one bit per rising edge.
REQ-007 SHALL have port cfg_data  input  1  serial data, LSB first, stable across cfg_sclk rising edge.
REQ-008 SHALL have port scale  output  16  committed frame bits [15:0].
REQ-009 SHALL have port start  output  16  committed frame bits [31:16].
REQ-010 SHALL have port max_iter  output  7  committed frame bits [38:32].
REQ-011 SHALL have port palette  output  3  committed frame bits [41:39].
REQ-012 SHALL have port ctr_mask  output  10  committed frame bits [51:42].
REQ-013 SHALL have port cfg_valid  output  1  one-cycle pulse on successful commit.
REQ-014 SHALL have port cfg_error  output  1  sticky flag: last frame discarded.
REQ-015 SHALL have port busy  output  1  high while state is SHIFT.

Function
REQ-016 SHALL pass cfg_en, cfg_sclk, cfg_data each through an identical SYNC_STAGES-deep synchronizer before any use; inputs are asynchronous to clk.
REQ-017 SHALL detect sclk rise as synchronized sclk 1 with previous-cycle synchronized sclk 0; same for en rise/fall.
REQ-018 SHALL implement FSM states IDLE, SHIFT, COMMIT.
REQ-019 IDLE: on en rise -> SHIFT, clear bit counter (6 bits) and shift register, clear cfg_error.
REQ-020 SHIFT: on each sclk rise while synchronized en high, shift synchronized data into MSB of CFG_BITS shift register (right shift), counter +1, saturating at 63.
REQ-021 SHIFT: on en fall -> COMMIT if counter == CFG_BITS, else -> IDLE with cfg_error set and shift register discarded.
REQ-022 SHALL ignore an sclk rise detected in the same cycle as en fall.
REQ-023 More than CFG_BITS edges SHALL produce counter != CFG_BITS and therefore an error at en fall; no partial commit.
REQ-024 COMMIT (one cycle): load all five outputs from shift register simultaneously, assert cfg_valid for exactly this cycle, -> IDLE.
REQ-025 Outputs SHALL change only in COMMIT; they hold last committed values otherwise, including during SHIFT and after errors.
REQ-026 Latency: en fall at pin -> outputs updated and cfg_valid high SYNC_STAGES+2 clk cycles later.
REQ-027 sclk edges while in IDLE (en low) SHALL be ignored.
REQ-028 SHALL require sclk high and low phases each >= SYNC_STAGES+1 clk cycles; faster sclk is out of contract.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, counter 0, shift register 0, synchronizers 0, cfg_valid 0, cfg_error 0, busy 0.
REQ-030 Reset values: scale 16'h8080, start 16'hC400, max_iter 7'h7F, palette 3'b000, ctr_mask 10'h00F.
REQ-031 Reset asserted mid-frame SHALL abort the frame; after release a fresh en rise is required before bits are accepted.

Verification
REQ-032 After reset, no stimulus -> outputs equal REQ-030 values, cfg_valid never pulses.
REQ-033 Frame {10'h03F,3'b010,7'h7F,16'hC400,16'h8080} LSB-first, 4-cycle sclk phases -> one cfg_valid pulse, ctr_mask 10'h03F, palette 3'b010, max_iter 7'h7F, start 16'hC400, scale 16'h8080, cfg_error 0.
REQ-034 Frame of 51 bits then en fall -> cfg_error 1, no cfg_valid, outputs unchanged.
REQ-035 Frame of 53 bits -> cfg_error 1, outputs unchanged; following valid 52-bit frame -> commits, cfg_error 0.
REQ-036 rst_n pulse after 20 bits of a frame -> outputs return to REQ-030 values; remaining 32 bits plus en fall -> no commit.
REQ-037 sclk toggled with en low, then valid frame -> only the 52 in-frame bits captured, commit matches sent frame.

Source files
------------

// File: rtl/config_receiver.sv
// Serial configuration receiver: synchronizes an external en/sclk/data loader,
// shifts a CFG_BITS frame LSB-first and commits it atomically to the field outputs.
module config_receiver #(
    parameter int CFG_BITS    = 52,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_en,
    input  logic        cfg_sclk,
    input  logic        cfg_data,
    output logic [15:0] scale,
    output logic [15:0] start,
    output logic [6:0]  max_iter,
    output logic [2:0]  palette,
    output logic [9:0]  ctr_mask,
    output logic        cfg_valid,
    output logic        cfg_error,
    output logic        busy
);

    // state  | meaning
    // IDLE   | waiting for a qualified en rise
    // SHIFT  | accepting bits on sclk rises until en falls
    // COMMIT | one cycle: load outputs from the shift register, pulse cfg_valid
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [SYNC_STAGES-1:0] en_sync_q,   en_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic [SYNC_STAGES-1:0] flush_q,     flush_d;
    logic                   en_prev_q,   en_prev_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   armed_q,     armed_d;

    logic [1:0]             state_q,     state_d;
    logic [5:0]             cnt_q,       cnt_d;
    logic [CFG_BITS-1:0]    shreg_q,     shreg_d;

    logic [15:0]            scale_q,     scale_d;
    logic [15:0]            start_q,     start_d;
    logic [6:0]             max_iter_q,  max_iter_d;
    logic [2:0]             palette_q,   palette_d;
    logic [9:0]             ctr_mask_q,  ctr_mask_d;
    logic                   cfg_valid_q, cfg_valid_d;
    logic                   cfg_error_q, cfg_error_d;

    logic en_s, sclk_s, data_s, sync_ready;
    logic en_rise, en_fall, sclk_rise;

    assign en_s       = en_sync_q[SYNC_STAGES-1];
    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign data_s     = data_sync_q[SYNC_STAGES-1];
    assign sync_ready = flush_q[SYNC_STAGES-1];

    // en must be seen low through a flushed synchronizer before a rise counts,
    // so an en held high across reset cannot restart a frame on release.
    assign en_rise   = en_s & ~en_prev_q & armed_q;
    assign en_fall   = ~en_s & en_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    always_comb begin
        en_sync_d   = {en_sync_q[SYNC_STAGES-2:0],   cfg_en};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], cfg_sclk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], cfg_data};
        flush_d     = {flush_q[SYNC_STAGES-2:0],     1'b1};
        en_prev_d   = en_s;
        sclk_prev_d = sclk_s;
        armed_d     = armed_q | (sync_ready & ~en_s);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        scale_d     = scale_q;
        start_d     = start_q;
        max_iter_d  = max_iter_q;
        palette_d   = palette_q;
        ctr_mask_d  = ctr_mask_q;
        cfg_valid_d = 1'b0;
        cfg_error_d = cfg_error_q;
        case (state_q)
            ST_IDLE: begin
                if (en_rise) begin
                    state_d     = ST_SHIFT;
                    cnt_d       = 6'd0;
                    shreg_d     = '0;
                    cfg_error_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (en_fall) begin
                    if (cnt_q == 6'(CFG_BITS)) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d     = ST_IDLE;
                        cfg_error_d = 1'b1;
                        shreg_d     = '0;
                    end
                end else if (sclk_rise && en_s) begin
                    shreg_d = {data_s, shreg_q[CFG_BITS-1:1]};
                    if (cnt_q != 6'd63) begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_COMMIT: begin
                scale_d     = shreg_q[15:0];
                start_d     = shreg_q[31:16];
                max_iter_d  = shreg_q[38:32];
                palette_d   = shreg_q[41:39];
                ctr_mask_d  = shreg_q[51:42];
                cfg_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sync_q   <= '0;
            sclk_sync_q <= '0;
            data_sync_q <= '0;
            flush_q     <= '0;
            en_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= 6'd0;
            shreg_q     <= '0;
            scale_q     <= 16'h8080;
            start_q     <= 16'hC400;
            max_iter_q  <= 7'h7F;
            palette_q   <= 3'b000;
            ctr_mask_q  <= 10'h00F;
            cfg_valid_q <= 1'b0;
            cfg_error_q <= 1'b0;
        end else begin
            en_sync_q   <= en_sync_d;
            sclk_sync_q <= sclk_sync_d;
            data_sync_q <= data_sync_d;
            flush_q     <= flush_d;
            en_prev_q   <= en_prev_d;
            sclk_prev_q <= sclk_prev_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            scale_q     <= scale_d;
            start_q     <= start_d;
            max_iter_q  <= max_iter_d;
            palette_q   <= palette_d;
            ctr_mask_q  <= ctr_mask_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    assign scale     = scale_q;
    assign start     = start_q;
    assign max_iter  = max_iter_q;
    assign palette   = palette_q;
    assign ctr_mask  = ctr_mask_q;
    assign cfg_valid = cfg_valid_q;
    assign cfg_error = cfg_error_q;
    assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_config_receiver.sv
// Directed bench for config_receiver: frame commit, latency, bit-count errors,
// mid-frame reset and idle sclk activity.
module tb_config_receiver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b0;
    logic        cfg_sclk = 1'b0;
    logic        cfg_data = 1'b0;
    logic [15:0] scale;
    logic [15:0] start;
    logic [6:0]  max_iter;
    logic [2:0]  palette;
    logic [9:0]  ctr_mask;
    logic        cfg_valid;
    logic        cfg_error;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cnt = 0;

    localparam logic [51:0] F_RST = {10'h00F, 3'b000, 7'h7F, 16'hC400, 16'h8080};
    localparam logic [51:0] F1    = {10'h03F, 3'b010, 7'h7F, 16'hC400, 16'h8080};
    localparam logic [51:0] F2    = {10'h2A5, 3'b101, 7'h15, 16'h1234, 16'hABCD};
    localparam logic [51:0] F3    = {10'h155, 3'b011, 7'h40, 16'hBEEF, 16'h0F0F};

    config_receiver #(.CFG_BITS(52), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .cfg_sclk  (cfg_sclk),
        .cfg_data  (cfg_data),
        .scale     (scale),
        .start     (start),
        .max_iter  (max_iter),
        .palette   (palette),
        .ctr_mask  (ctr_mask),
        .cfg_valid (cfg_valid),
        .cfg_error (cfg_error),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cfg_valid) valid_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input string tag, input logic [51:0] f);
        logic [51:0] obs;
        obs = {ctr_mask, palette, max_iter, start, scale};
        check({tag, "_fields"}, 64'(obs), 64'(f));
    endtask

    task automatic send_bit(input logic b);
        cfg_data = b;
        repeat (4) @(negedge clk);
        cfg_sclk = 1'b1;
        repeat (4) @(negedge clk);
        cfg_sclk = 1'b0;
    endtask

    // bits past 52 are sent as 1 so an overlong frame is visibly different
    task automatic send_bits(input logic [51:0] f, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            send_bit((i < 52) ? f[i] : 1'b1);
        end
    endtask

    task automatic end_frame(input string tag, input logic exp_busy, input logic exp_commit);
        repeat (4) @(negedge clk);
        check({tag, "_busy"}, 64'(busy), 64'(exp_busy));
        cfg_en = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_valid_early"}, 64'(cfg_valid), 64'd0);
        @(negedge clk);
        check({tag, "_valid_at_lat"}, 64'(cfg_valid), 64'(exp_commit));
        repeat (6) @(negedge clk);
    endtask

    task automatic full_frame(input string tag, input logic [51:0] f, input int n, input logic exp_commit);
        cfg_en = 1'b1;
        repeat (6) @(negedge clk);
        send_bits(f, 0, n);
        end_frame(tag, 1'b1, exp_commit);
    endtask

    initial begin
        int v0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // reset state, no stimulus
        check_fields("reset", F_RST);
        check("reset_error", 64'(cfg_error), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_valid_cnt", 64'(valid_cnt), 64'd0);

        // nominal frame
        v0 = valid_cnt;
        full_frame("f1", F1, 52, 1'b1);
        check_fields("f1", F1);
        check("f1_error", 64'(cfg_error), 64'd0);
        check("f1_pulses", 64'(valid_cnt - v0), 64'd1);

        // short frame
        v0 = valid_cnt;
        full_frame("short", F2, 51, 1'b0);
        check("short_error", 64'(cfg_error), 64'd1);
        check("short_pulses", 64'(valid_cnt - v0), 64'd0);
        check_fields("short", F1);

        // long frame then recovery
        v0 = valid_cnt;
        full_frame("long", F2, 53, 1'b0);
        check("long_error", 64'(cfg_error), 64'd1);
        check("long_pulses", 64'(valid_cnt - v0), 64'd0);
        check_fields("long", F1);
        full_frame("recover", F2, 52, 1'b1);
        check_fields("recover", F2);
        check("recover_error", 64'(cfg_error), 64'd0);

        // reset after 20 bits, en held high throughout
        v0 = valid_cnt;
        cfg_en = 1'b1;
        repeat (6) @(negedge clk);
        send_bits(F3, 0, 20);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy_async", 64'(busy), 64'd0);
        check_fields("midrst_async", F_RST);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_bits(F3, 20, 32);
        end_frame("midrst", 1'b0, 1'b0);
        check("midrst_pulses", 64'(valid_cnt - v0), 64'd0);
        check_fields("midrst", F_RST);

        // sclk activity with en low, then a clean frame
        v0 = valid_cnt;
        for (int k = 0; k < 5; k++) send_bit(1'b1);
        repeat (4) @(negedge clk);
        check("idle_sclk_busy", 64'(busy), 64'd0);
        check("idle_sclk_pulses", 64'(valid_cnt - v0), 64'd0);
        full_frame("f3", F3, 52, 1'b1);
        check_fields("f3", F3);
        check("f3_error", 64'(cfg_error), 64'd0);
        check("f3_pulses", 64'(valid_cnt - v0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
